// File: rtl/riscv_div_seq.sv
// riscv_div_seq
// Iterative restoring divider for RISC-V DIV/DIVU/REM/REMU. One trial
// subtraction per cycle, WIDTH iterations, then one sign-fix cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish
// in a single cycle with the architecturally mandated results.
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : request, sampled only in IDLE
//   op        : funct3[1:0] (00 DIV, 01 DIVU, 10 REM, 11 REMU)
//   dividend  : rs1, sampled with start
//   divisor   : rs2, sampled with start
//   flush     : abort any operation, return to IDLE without done
//   busy      : high in every non-IDLE state
//   done      : one-cycle pulse, result valid
//   result    : quotient or remainder, held until the next accepted op
//
// state  | meaning
// IDLE   | waiting for start
// CALC   | one shift/subtract iteration per cycle
// FIX    | sign correction and quotient/remainder select
// DONE   | result valid, done pulse
module riscv_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [1:0]       op_q;
  logic [WIDTH-1:0] quo;       // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] dvs;       // |divisor|
  logic [WIDTH-1:0] rem;
  logic [CNT_W-1:0] cnt;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] result_q;

  logic             is_signed;
  logic             div_zero;
  logic             ovf;
  logic             special;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] special_res;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] fix_res;

  assign is_signed = ~op[0];
  assign div_zero  = (divisor == '0);
  assign ovf       = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                     && (divisor == '1);
  assign special   = div_zero | ovf;

  // The most negative dividend maps to itself, which is the correct
  // unsigned magnitude.
  assign abs_a = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign abs_b = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  // Divide by zero: quotient all ones, remainder = dividend.
  // Overflow: quotient = dividend (most negative), remainder 0.
  assign special_res = div_zero ? (op[1] ? dividend : '1)
                                : (op[1] ? '0 : dividend);

  // Shifted remainder minus divisor; bit WIDTH set means negative.
  assign trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};

  assign q_fix   = neg_q ? -quo : quo;
  assign r_fix   = neg_r ? -rem : rem;
  assign fix_res = op_q[1] ? r_fix : q_fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) state_nxt = special ? S_DONE : S_CALC;
        S_CALC: if (cnt == '0) state_nxt = S_FIX;
        S_FIX:  state_nxt = S_DONE;
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  assign result = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      quo      <= '0;
      dvs      <= '0;
      rem      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
    end else if (!flush) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op;
            neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= is_signed & dividend[WIDTH-1];
            quo   <= abs_a;
            dvs   <= abs_b;
            rem   <= '0;
            cnt   <= CNT_W'(WIDTH-1);
            if (special) result_q <= special_res;
          end
        end
        S_CALC: begin
          if (trial[WIDTH]) begin
            rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
          end else begin
            rem <= trial[WIDTH-1:0];
          end
          quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
          cnt <= cnt - CNT_W'(1);
        end
        S_FIX: begin
          result_q <= fix_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/riscv_div_seq.md
# riscv_div_seq

Iterative 32-cycle restoring divider for the RISC-V M-extension operations DIV, DIVU, REM and REMU. It sits alongside the combinational Brent-Kung add/sub unit in the ALU. Where that unit completes an add or subtract in one cycle, this block performs the inverse of multiplication by repeated shift-and-subtract, using one trial subtraction per cycle. The execute stage issues it through a start/busy/done handshake and stalls until `done`.

## Interface

Parameters
- `WIDTH`, default 32: operand and result width. The iteration count equals `WIDTH`.

Ports
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request. Sampled only in IDLE.
- `op`, input, 2: operation select, equal to funct3[1:0]. 00 = DIV, 01 = DIVU, 10 = REM, 11 = REMU.
- `dividend`, input, WIDTH: rs1. Sampled with `start`.
- `divisor`, input, WIDTH: rs2. Sampled with `start`.
- `flush`, input, 1: pipeline kill. Aborts any operation in flight.
- `busy`, output, 1: high in every non-IDLE state.
- `done`, output, 1: one-cycle pulse when `result` is valid.
- `result`, output, WIDTH: quotient for DIV/DIVU, remainder for REM/REMU. Held until the next accepted `start`.

## Operation

- The clock is named `clk` and the reset `rst_n`. Reset is asynchronous and active-low.
- States: IDLE, CALC, FIX, DONE.
- IDLE with `start`=1: latch `op` and the operands, then classify.
  - Divisor == 0: go to DONE with the special result.
  - Signed op with dividend == 0x80000000 and divisor == 0xFFFFFFFF: go to DONE with the special result.
  - Otherwise: go to CALC. Load the absolute values (signed ops) or raw values (unsigned ops), clear the partial remainder, set the iteration counter to WIDTH-1.
- CALC, one iteration per cycle:
  - Shift the partial remainder left, taking in the dividend MSB.
  - Trial = remainder − |divisor|, computed in WIDTH+1 bits.
  - If trial ≥ 0: keep the trial and shift in quotient bit 1. Otherwise: restore the remainder and shift in 0.
  - Decrement the counter. Go to FIX after the iteration with counter == 0.
- FIX, sign correction for signed ops only:
  - Negate the quotient when the dividend and divisor signs differ.
  - Negate the remainder when the dividend is negative.
  - Select the quotient or remainder per `op`, then go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Special results (RISC-V mandated):
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return the dividend unchanged.
  - Signed overflow: DIV returns 0x80000000; REM returns 0.
- `start` while `busy`=1 is ignored. Operands are not re-sampled.
- `flush`=1 in any state: next state is IDLE, `done` is not asserted, and `result` keeps its previous value. `flush` and `start` together in IDLE: `flush` wins and the request is dropped.
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0. Counter and operand registers are cleared.

## Timing

- Normal op, `start` sampled at edge T:
  - CALC occupies cycles T+1 through T+WIDTH.
  - FIX occupies cycle T+WIDTH+1.
  - `done`=1 during cycle T+WIDTH+2 (T+34 for WIDTH=32).
- Special case: `done`=1 during cycle T+1.
- `busy` rises in the cycle after the `start` edge. It falls in the cycle after DONE, when IDLE is re-entered.
- A new `start` is accepted in the first IDLE cycle after DONE. The fastest back-to-back issue is therefore every WIDTH+3 cycles.
- `result` changes only on the edge that enters DONE. It is stable whenever `done`=1.
- The divider has no combinational path from inputs to outputs.

## Test plan

- DIV 100 / 7 → `result`=14, `done` 34 cycles after `start`. REM with the same operands → 2.
- DIV −100 / 7 → 0xFFFFFFF2 (−14). REM −100 / 7 → 0xFFFFFFFE (−2). DIVU 0xFFFFFFFF / 2 → 0x7FFFFFFF.
- DIV 5 / 0 → 0xFFFFFFFF. REMU 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM with the same operands → 0. `done` 1 cycle after `start` in all four cases.
- Issue DIVU 1000 / 3, pulse `start` again with new operands at cycle 5 → second request ignored, result 333, exactly one `done`.
- Issue DIV, assert `flush` at cycle 10 → `busy`=0 the next cycle, no `done`, `result` unchanged. An immediate new DIVU 9 / 3 → 3.
- Assert `rst_n`=0 mid-CALC, asynchronously between edges → `busy`, `done` and `result` read 0 immediately. After release, a new DIV 50 / 5 → 10.
